// File: rtl/bch_chien_search_if.sv
// Locator-polynomial handshake between the Berlekamp stage (master) and the Chien search (slave).
// oerr_cnt exists only when BCH_CHIEN_ERRCNT_EN is defined.
interface bch_chien_search_if #(
  parameter int m     = 4,
  parameter int t     = 3,
  parameter int PTR_W = 3
);
  localparam int CW = $clog2(t + 2);

  logic                  iloc_poly_val;
  logic [t:0][m-1:0]     iloc_poly;
  logic [PTR_W-1:0]      iloc_poly_ptr;
  logic                  iloc_failed;
  logic                  ordy;
  logic                  oval;
  logic                  osop;
  logic                  oeop;
  logic                  oerr;
  logic                  odecfail;
`ifdef BCH_CHIEN_ERRCNT_EN
  logic [CW-1:0]         oerr_cnt;
`endif

  modport master (
    output iloc_poly_val, iloc_poly, iloc_poly_ptr, iloc_failed,
`ifdef BCH_CHIEN_ERRCNT_EN
    input  oerr_cnt,
`endif
    input  ordy, oval, osop, oeop, oerr, odecfail
  );

  modport slave (
    input  iloc_poly_val, iloc_poly, iloc_poly_ptr, iloc_failed,
`ifdef BCH_CHIEN_ERRCNT_EN
    output oerr_cnt,
`endif
    output ordy, oval, osop, oeop, oerr, odecfail
  );
endinterface

// File: rtl/bch_chien_search.sv
// Sequential Chien search: one codeword position per clock, MSB first, with end-of-frame failure check.
// Optional macro BCH_CHIEN_ERRCNT_EN adds the saturated root-count output oerr_cnt.
module bch_chien_search #(
  parameter int         m       = 4,
  parameter int         n       = 15,
  parameter int         t       = 3,
  parameter logic [m:0] irrpoly = 5'b10011,
  parameter int         PTR_W   = 3
) (
  input  logic                 iclk,
  input  logic                 ireset,
  bch_chien_search_if.slave    loc
);
  localparam int NF    = 2**m - 1;
  localparam int CW    = $clog2(t + 2);
  localparam int KW    = (n > 1) ? $clog2(n) : 1;
  localparam int SHIFT = NF - n + 1;

  typedef enum logic {IDLE, SEARCH} state_e;

  state_e            state_q, state_d;
  logic [t:0][m-1:0] r_q, r_d;
  logic [KW-1:0]     k_q, k_d;
  logic              failed_q, failed_d;
  logic [CW-1:0]     deg_q, deg_d;
  logic [CW-1:0]     rootCnt_q, rootCnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic [m-1:0]      evalSum;
  logic              hit;
  logic              lastPos;
  logic              loadEn;
  logic              rdy;
  logic [CW-1:0]     cntNext;
  logic [CW-1:0]     loadDeg;

  function automatic logic [m-1:0] xtime(input logic [m-1:0] a);
    return {a[m-2:0], 1'b0} ^ (a[m-1] ? irrpoly[m-1:0] : '0);
  endfunction

  function automatic logic [m-1:0] gfMul(input logic [m-1:0] a, input logic [m-1:0] b);
    logic [m-1:0] acc;
    logic [m-1:0] sh;
    acc = '0;
    sh  = a;
    for (int j = 0; j < m; j++) begin
      if (b[j]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Only ever called with elaboration-time exponents, so it folds to a constant.
  function automatic logic [m-1:0] alphaPow(input int e);
    logic [m-1:0] p;
    int           em;
    p  = {{(m-1){1'b0}}, 1'b1};
    em = e % NF;
    for (int j = 0; j < NF; j++) begin
      if (j < em) p = xtime(p);
    end
    return p;
  endfunction

  always_comb begin
    evalSum = '0;
    for (int i = 0; i <= t; i++) evalSum = evalSum ^ r_q[i];
  end

  always_comb begin
    loadDeg = '0;
    for (int i = 0; i <= t; i++) begin
      if (loc.iloc_poly[i] != '0) loadDeg = CW'(i);
    end
  end

  assign hit     = (state_q == SEARCH) && (evalSum == '0);
  assign lastPos = (state_q == SEARCH) && (k_q == KW'(n - 1));
  assign cntNext = (hit && (rootCnt_q != CW'(t + 1))) ? rootCnt_q + 1'b1 : rootCnt_q;
  assign rdy     = (state_q == IDLE) || lastPos;
  assign loadEn  = loc.iloc_poly_val && rdy;

  // A load on the final search cycle starts the next frame with no idle gap.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    k_d       = k_q;
    failed_d  = failed_q;
    deg_d     = deg_q;
    rootCnt_d = rootCnt_q;
    ptr_d     = ptr_q;
    if (state_q == SEARCH) begin
      for (int i = 0; i <= t; i++) r_d[i] = gfMul(r_q[i], alphaPow(i));
      k_d       = k_q + 1'b1;
      rootCnt_d = cntNext;
      if (lastPos) state_d = IDLE;
    end
    if (loadEn) begin
      state_d   = SEARCH;
      k_d       = '0;
      rootCnt_d = '0;
      failed_d  = loc.iloc_failed | (loc.iloc_poly[0] == '0);
      deg_d     = loadDeg;
      ptr_d     = loc.iloc_poly_ptr;
      for (int i = 0; i <= t; i++) r_d[i] = gfMul(loc.iloc_poly[i], alphaPow(i * SHIFT));
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q   <= IDLE;
      r_q       <= '0;
      k_q       <= '0;
      failed_q  <= 1'b0;
      deg_q     <= '0;
      rootCnt_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      k_q       <= k_d;
      failed_q  <= failed_d;
      deg_q     <= deg_d;
      rootCnt_q <= rootCnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign loc.ordy     = rdy;
  assign loc.oval     = (state_q == SEARCH);
  assign loc.osop     = (state_q == SEARCH) && (k_q == '0);
  assign loc.oeop     = lastPos;
  assign loc.oerr     = hit;
  assign loc.odecfail = lastPos && (failed_q || (cntNext != deg_q));
`ifdef BCH_CHIEN_ERRCNT_EN
  assign loc.oerr_cnt = lastPos ? cntNext : '0;
`endif
endmodule

// File: tb/tb_bch_chien_search.sv
// Self-checking bench for bch_chien_search: directed frames plus randomized locators
// checked against a log/antilog-table evaluation of the locator polynomial.
module tb_bch_chien_search;
  localparam int M  = 4;
  localparam int NL = 15;
  localparam int T  = 3;
  localparam int NF = 15;

  typedef logic [T:0][M-1:0] lam_t;

  logic iclk = 1'b0;
  logic ireset;
  int   total = 0;
  int   bad   = 0;
  int   expTab [0:NF-1];
  int   logTab [0:NF];

  always #5 iclk = ~iclk;

  bch_chien_search_if #(.m(M), .t(T), .PTR_W(3)) loc ();

  bch_chien_search #(.m(M), .n(NL), .t(T), .irrpoly(5'b10011), .PTR_W(3)) dut (
    .iclk   (iclk),
    .ireset (ireset),
    .loc    (loc)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int gm(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return expTab[(logTab[a] + logTab[b]) % NF];
  endfunction

  // Lambda(x) = sum lam_i * x^i, with x^i taken straight from the antilog table.
  function automatic int evalAt(input lam_t lam, input int x);
    int acc;
    acc = 0;
    for (int i = 0; i <= T; i++)
      acc ^= gm(int'(lam[i]), (i == 0) ? 1 : expTab[(logTab[x] * i) % NF]);
    return acc;
  endfunction

  task automatic computeModel(input lam_t lam, input logic failed,
                              output logic [NL-1:0] errV, output int fail, output int cnt);
    int roots;
    int deg;
    int p;
    roots = 0;
    deg   = 0;
    for (int k = 0; k < NL; k++) begin
      p       = NL - 1 - k;
      errV[k] = (evalAt(lam, expTab[(NF - p) % NF]) == 0);
      roots  += int'(errV[k]);
    end
    for (int i = 0; i <= T; i++) if (lam[i] != 0) deg = i;
    cnt  = (roots > T + 1) ? T + 1 : roots;
    fail = int'(failed || lam[0] == 0 || cnt != deg);
  endtask

  function automatic lam_t mkLam(input int a0, input int a1, input int a2, input int a3);
    lam_t l;
    l[0] = 4'(a0); l[1] = 4'(a1); l[2] = 4'(a2); l[3] = 4'(a3);
    return l;
  endfunction

  // Locator with roots at alpha^-p for each chosen error position p.
  function automatic lam_t genLam();
    lam_t    l;
    int      c [0:T];
    int      nerr;
    int      p;
    bit [NL-1:0] used;
    if ($urandom_range(0, 3) == 3) begin
      for (int i = 0; i <= T; i++) l[i] = 4'($urandom_range(0, 15));
      return l;
    end
    c[0] = 1;
    for (int i = 1; i <= T; i++) c[i] = 0;
    used = '0;
    nerr = $urandom_range(0, T);
    for (int e = 0; e < nerr; e++) begin
      do p = $urandom_range(0, NL - 1); while (used[p]);
      used[p] = 1'b1;
      for (int i = T; i >= 1; i--) c[i] ^= gm(expTab[p], c[i-1]);
    end
    for (int i = 0; i <= T; i++) l[i] = 4'(c[i]);
    return l;
  endfunction

  task automatic applyStimulus(input lam_t lam, input logic failed);
    loc.iloc_poly     = lam;
    loc.iloc_failed   = failed;
    loc.iloc_poly_ptr = 3'($urandom);
    loc.iloc_poly_val = 1'b1;
  endtask

  task automatic idleCheck(input string tag);
    @(negedge iclk);
    loc.iloc_poly_val = 1'b0;
    checkOutput({tag, ".idle.oval"}, 32'(loc.oval), 0);
    checkOutput({tag, ".idle.ordy"}, 32'(loc.ordy), 1);
  endtask

  // Called right after applyStimulus at a negedge; walks the frame one position per cycle.
  task automatic runFrame(input string tag, input lam_t lam, input logic failed,
                          input bit chain, input lam_t lamNext, input logic failedNext,
                          input bit midInject, input int resetAt);
    logic [NL-1:0] errV;
    int fail;
    int cnt;
    computeModel(lam, failed, errV, fail, cnt);
    for (int k = 0; k < NL; k++) begin
      @(negedge iclk);
      loc.iloc_poly_val = 1'b0;
      if (k == resetAt) begin
        ireset = 1'b1;
        #1;
        checkOutput({tag, ".rst.oval"}, 32'(loc.oval), 0);
        checkOutput({tag, ".rst.osop"}, 32'(loc.osop), 0);
        checkOutput({tag, ".rst.oeop"}, 32'(loc.oeop), 0);
        checkOutput({tag, ".rst.oerr"}, 32'(loc.oerr), 0);
        checkOutput({tag, ".rst.odecfail"}, 32'(loc.odecfail), 0);
        checkOutput({tag, ".rst.ordy"}, 32'(loc.ordy), 1);
        return;
      end
      checkOutput($sformatf("%s.k%0d.oval", tag, k), 32'(loc.oval), 1);
      checkOutput($sformatf("%s.k%0d.osop", tag, k), 32'(loc.osop), 32'(k == 0));
      checkOutput($sformatf("%s.k%0d.oeop", tag, k), 32'(loc.oeop), 32'(k == NL - 1));
      checkOutput($sformatf("%s.k%0d.oerr", tag, k), 32'(loc.oerr), 32'(errV[k]));
      checkOutput($sformatf("%s.k%0d.odecfail", tag, k), 32'(loc.odecfail),
                  (k == NL - 1) ? 32'(fail) : 0);
      checkOutput($sformatf("%s.k%0d.ordy", tag, k), 32'(loc.ordy), 32'(k == NL - 1));
`ifdef BCH_CHIEN_ERRCNT_EN
      checkOutput($sformatf("%s.k%0d.oerr_cnt", tag, k), 32'(loc.oerr_cnt),
                  (k == NL - 1) ? 32'(cnt) : 0);
`endif
      if (midInject && (k == 5 || k == 9)) applyStimulus(genLam(), 1'b0);
      if (chain && k == NL - 1) applyStimulus(lamNext, failedNext);
    end
  endtask

  initial begin
    lam_t cur, nxt;
    logic fc, fn;
    bit   chain;
    int   e;

    e = 1;
    for (int i = 0; i < NF; i++) begin
      expTab[i] = e;
      logTab[e] = i;
      e = e << 1;
      if ((e & 16) != 0) e ^= 'b10011;
    end
    logTab[0] = 0;

    ireset            = 1'b1;
    loc.iloc_poly_val = 1'b0;
    loc.iloc_poly     = '0;
    loc.iloc_poly_ptr = '0;
    loc.iloc_failed   = 1'b0;
    repeat (2) @(negedge iclk);
    checkOutput("reset.oval", 32'(loc.oval), 0);
    checkOutput("reset.osop", 32'(loc.osop), 0);
    checkOutput("reset.oeop", 32'(loc.oeop), 0);
    checkOutput("reset.oerr", 32'(loc.oerr), 0);
    checkOutput("reset.odecfail", 32'(loc.odecfail), 0);
    checkOutput("reset.ordy", 32'(loc.ordy), 1);
    ireset = 1'b0;

    @(negedge iclk);
    applyStimulus(mkLam(1, 0, 0, 0), 1'b0);
    runFrame("noerr", mkLam(1, 0, 0, 0), 1'b0, 0, '0, 1'b0, 0, -1);
    idleCheck("noerr");

    applyStimulus(mkLam(1, 6, 0, 0), 1'b0);
    runFrame("single", mkLam(1, 6, 0, 0), 1'b0, 0, '0, 1'b0, 0, -1);
    idleCheck("single");

    applyStimulus(mkLam(1, 8, 9, 0), 1'b0);
    runFrame("double", mkLam(1, 8, 9, 0), 1'b0, 0, '0, 1'b0, 0, -1);
    idleCheck("double");

    applyStimulus(mkLam(1, 15, 15, 0), 1'b0);
    runFrame("mismatch", mkLam(1, 15, 15, 0), 1'b0, 0, '0, 1'b0, 0, -1);
    idleCheck("mismatch");

    applyStimulus(mkLam(1, 0, 0, 0), 1'b1);
    runFrame("upfail", mkLam(1, 0, 0, 0), 1'b1, 0, '0, 1'b0, 0, -1);
    idleCheck("upfail");

    applyStimulus(mkLam(1, 6, 0, 0), 1'b0);
    runFrame("b2bA", mkLam(1, 6, 0, 0), 1'b0, 1, mkLam(1, 8, 9, 0), 1'b0, 0, -1);
    runFrame("b2bB", mkLam(1, 8, 9, 0), 1'b0, 0, '0, 1'b0, 0, -1);
    idleCheck("b2bB");

    applyStimulus(mkLam(1, 8, 9, 0), 1'b0);
    runFrame("midval", mkLam(1, 8, 9, 0), 1'b0, 0, '0, 1'b0, 1, -1);
    idleCheck("midval");

    applyStimulus(mkLam(1, 6, 0, 0), 1'b0);
    runFrame("abort", mkLam(1, 6, 0, 0), 1'b0, 0, '0, 1'b0, 0, 7);
    @(negedge iclk);
    checkOutput("abort.held.oval", 32'(loc.oval), 0);
    ireset = 1'b0;
    for (int i = 0; i < NL; i++) begin
      @(negedge iclk);
      checkOutput($sformatf("abort.after%0d.oval", i), 32'(loc.oval), 0);
      checkOutput($sformatf("abort.after%0d.oeop", i), 32'(loc.oeop), 0);
    end
    applyStimulus(mkLam(1, 6, 0, 0), 1'b0);
    runFrame("postabort", mkLam(1, 6, 0, 0), 1'b0, 0, '0, 1'b0, 0, -1);
    idleCheck("postabort");

    cur = genLam();
    fc  = ($urandom_range(0, 7) == 0);
    applyStimulus(cur, fc);
    for (int f = 0; f < 24; f++) begin
      nxt   = genLam();
      fn    = ($urandom_range(0, 7) == 0);
      chain = (f < 23) && ($urandom_range(0, 1) == 1);
      runFrame($sformatf("rnd%0d", f), cur, fc, chain, nxt, fn, 0, -1);
      if (!chain) begin
        idleCheck($sformatf("rnd%0d", f));
        if (f < 23) applyStimulus(nxt, fn);
      end
      cur = nxt;
      fc  = fn;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
